// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding for counter blocks and their benches
package counter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
endpackage

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter with pause, one-cycle done pulse and optional auto-reload
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int N_BITS = 4
) (
  input  logic              clk,
  input  logic              syn_rst,
  input  logic              load,
  input  logic [N_BITS-1:0] load_val,
  input  logic              start,
  input  logic              pause,
  input  logic              auto_reload,
  output logic [N_BITS-1:0] count,
  output logic              done,
  output logic              busy
);
  localparam logic [N_BITS-1:0] ONE = 1;
  state_t            r_state;
  logic [N_BITS-1:0] r_reload;
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      r_state  <= IDLE;
      r_reload <= '0;
      count    <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else if (load) begin
      r_state  <= IDLE;
      r_reload <= load_val;
      count    <= load_val;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          // zero-length countdown: pulse immediately, but never on back-to-back cycles
          if (count == '0) done <= !done;
          else begin
            r_state <= RUN;
            busy    <= 1'b1;
          end
        end
        RUN: if (pause) r_state <= PAUSE;
        else if (count <= ONE) begin
          r_state <= DONE;
          count   <= '0;
          done    <= 1'b1;
          busy    <= 1'b0;
        end else count <= count - ONE;
        PAUSE: if (!pause) r_state <= RUN;
        DONE: if (auto_reload && r_reload != '0) begin
          r_state <= RUN;
          count   <= r_reload;
          busy    <= 1'b1;
        end else r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed checks of countdown, pause, auto-reload, zero start, abort and start-ignore
module tb_down_counter_timer;
  logic       clk = 1'b0;
  logic       syn_rst, load, start, pause, auto_reload;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       done, busy;
  int checks = 0;
  int errors = 0;

  down_counter_timer #(.N_BITS(4)) dut (
    .clk(clk), .syn_rst(syn_rst), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .auto_reload(auto_reload),
    .count(count), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input int d, input int b);
    checks++;
    assert (int'(count) === c) else begin
      errors++;
      $error("FAIL %s count observed %0d expected %0d", tag, count, c);
    end
    checks++;
    assert (int'(done) === d) else begin
      errors++;
      $error("FAIL %s done observed %0d expected %0d", tag, done, d);
    end
    checks++;
    assert (int'(busy) === b) else begin
      errors++;
      $error("FAIL %s busy observed %0d expected %0d", tag, busy, b);
    end
  endtask

  initial begin
    syn_rst = 1; load = 0; load_val = 0; start = 0; pause = 0; auto_reload = 0;
    tick(); chk("reset", 0, 0, 0);
    syn_rst = 0;
    // basic countdown from 3
    load = 1; load_val = 3; tick(); chk("basic_load", 3, 0, 0);
    load = 0; start = 1; tick(); chk("basic_start", 3, 0, 1);
    start = 0; tick(); chk("basic_2", 2, 0, 1);
    tick(); chk("basic_1", 1, 0, 1);
    tick(); chk("basic_0", 0, 1, 0);
    tick(); chk("basic_idle", 0, 0, 0);
    pause = 1; tick(); chk("idle_pause_ignored", 0, 0, 0);
    pause = 0;
    // pause while count = 4
    load = 1; load_val = 5; tick(); chk("pause_load", 5, 0, 0);
    load = 0; start = 1; tick(); chk("pause_start", 5, 0, 1);
    start = 0; tick(); chk("pause_4", 4, 0, 1);
    pause = 1; tick(); chk("pause_h1", 4, 0, 1);
    tick(); chk("pause_h2", 4, 0, 1);
    tick(); chk("pause_h3", 4, 0, 1);
    pause = 0; tick(); chk("pause_resume", 4, 0, 1);
    tick(); chk("pause_3", 3, 0, 1);
    tick(); chk("pause_2", 2, 0, 1);
    tick(); chk("pause_1", 1, 0, 1);
    tick(); chk("pause_0", 0, 1, 0);
    tick(); chk("pause_idle", 0, 0, 0);
    // auto-reload with period 3
    load = 1; load_val = 2; auto_reload = 1; tick(); chk("ar_load", 2, 0, 0);
    load = 0; start = 1; tick(); chk("ar_start", 2, 0, 1);
    start = 0; tick(); chk("ar_1a", 1, 0, 1);
    tick(); chk("ar_0a", 0, 1, 0);
    tick(); chk("ar_2b", 2, 0, 1);
    tick(); chk("ar_1b", 1, 0, 1);
    tick(); chk("ar_0b", 0, 1, 0);
    tick(); chk("ar_2c", 2, 0, 1);
    auto_reload = 0; tick(); chk("ar_1c", 1, 0, 1);
    tick(); chk("ar_0c", 0, 1, 0);
    tick(); chk("ar_idle", 0, 0, 0);
    tick(); chk("ar_idle_hold", 0, 0, 0);
    // zero start
    load = 1; load_val = 0; tick(); chk("zero_load", 0, 0, 0);
    load = 0; start = 1; tick(); chk("zero_start", 0, 1, 0);
    start = 0; tick(); chk("zero_after", 0, 0, 0);
    // abort with reset at count 9
    load = 1; load_val = 15; tick(); chk("abort_load", 15, 0, 0);
    load = 0; start = 1; tick(); chk("abort_start", 15, 0, 1);
    start = 0;
    for (int i = 14; i >= 9; i--) begin
      tick(); chk("abort_run", i, 0, 1);
    end
    syn_rst = 1; tick(); chk("abort_rst", 0, 0, 0);
    syn_rst = 0; tick(); chk("abort_idle", 0, 0, 0);
    // load mid-run
    load = 1; load_val = 4; tick(); chk("midload_load", 4, 0, 0);
    load = 0; start = 1; tick(); chk("midload_start", 4, 0, 1);
    start = 0; tick(); chk("midload_3", 3, 0, 1);
    load = 1; load_val = 7; tick(); chk("midload_7", 7, 0, 0);
    load = 0; tick(); chk("midload_idle", 7, 0, 0);
    // load wins over start
    load = 1; load_val = 6; start = 1; tick(); chk("load_over_start", 6, 0, 0);
    load = 0; tick(); chk("ign_start", 6, 0, 1);
    // start held during run is ignored
    tick(); chk("ign_5", 5, 0, 1);
    tick(); chk("ign_4", 4, 0, 1);
    start = 0; tick(); chk("ign_3", 3, 0, 1);
    tick(); chk("ign_2", 2, 0, 1);
    tick(); chk("ign_1", 1, 0, 1);
    tick(); chk("ign_0", 0, 1, 0);
    tick(); chk("ign_idle", 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 The block SHALL have parameter N_BITS, default 4, setting the width of the count and load value.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port syn_rst, input, 1 bit, a synchronous active-high reset sampled on the rising clk edge.
REQ-004 The block SHALL have port load, input, 1 bit, which captures load_val into count and the reload register.
REQ-005 The block SHALL have port load_val, input, N_BITS, the start value for the countdown.
REQ-006 The block SHALL have port start, input, 1 bit, which begins the countdown from IDLE.
REQ-007 The block SHALL have port pause, input, 1 bit, which freezes the countdown while high.
REQ-008 The block SHALL have port auto_reload, input, 1 bit, which restarts from the reload register after terminal count.
REQ-009 The block SHALL have port count, output, N_BITS, the current counter value.
REQ-010 The block SHALL have port done, output, 1 bit, a registered one-cycle pulse at terminal count.
REQ-011 The block SHALL have port busy, output, 1 bit, high in RUN or PAUSE.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE.
REQ-013 Priority SHALL be: syn_rst > load > start/pause > normal counting.
REQ-014 When load is high in any state, the block SHALL set count and reload_reg to load_val, go to IDLE, and drive done low next cycle.
REQ-015 In IDLE with start high and count != 0, the block SHALL go to RUN with count unchanged that cycle.
REQ-016 In IDLE with start high and count == 0, the block SHALL stay in IDLE and pulse done for one cycle.
REQ-017 In RUN with pause low, the block SHALL decrement count by exactly 1 per cycle.
REQ-018 In RUN with pause high, the block SHALL go to PAUSE and hold count.
REQ-019 In PAUSE, the block SHALL hold count while pause is high, and return to RUN with no decrement in that transition cycle when pause is low.
REQ-020 In RUN with count == 1 and pause low, the block SHALL set count to 0, assert done next cycle, and go to DONE.
REQ-021 DONE SHALL last exactly one cycle.
REQ-022 In DONE with auto_reload high and reload_reg != 0, the block SHALL set count to reload_reg and go to RUN.
REQ-023 In DONE otherwise, the block SHALL go to IDLE with count held at 0.
REQ-024 With auto_reload high, the done period SHALL equal reload_reg + 1 cycles.
REQ-025 count SHALL never wrap below 0 and never change in IDLE except by load.
REQ-026 start SHALL be ignored outside IDLE, and pause SHALL be ignored in IDLE and DONE.
REQ-027 done SHALL never be high for two consecutive cycles.

Reset
REQ-028 On syn_rst high, the block SHALL set the state to IDLE and clear count, reload_reg, done and busy to 0 on the same clk edge.
REQ-029 syn_rst asserted mid-RUN or mid-PAUSE SHALL abort the countdown with no done pulse.
REQ-030 All outputs SHALL be registered; no output SHALL depend combinationally on inputs.

Structure
REQ-031 The state enum type SHALL reside in shared package counter_pkg for reuse by benches and sibling counters.
REQ-032 The block SHALL be a single module with no sub-module; the FSM and datapath SHALL live in one always_ff block plus next-state logic.

Verification (N_BITS = 4)
REQ-033 Basic countdown: load 3, then start -> count reads 3, 3, 2, 1, 0; done high in exactly the cycle count first reads 0; then IDLE with busy low.
REQ-034 Pause: load 5, start, pause high for 3 cycles after count = 4 -> count holds 4 for 4 cycles, then resumes 3, 2, 1, 0; one done pulse.
REQ-035 Auto-reload: load 2, auto_reload high, start -> done pulses every 3 cycles with count sequence 2, 1, 0, 2, 1, 0 repeating.
REQ-036 Zero start: load 0, start -> single done pulse, busy never high, count stays 0.
REQ-037 Abort: load 15, start, syn_rst at count = 9 -> count 0 and IDLE next cycle, no done; load 7 mid-RUN -> count 7, IDLE.
REQ-038 Start ignored: start asserted during RUN -> no restart, and the countdown is unaffected.
